uart_fifo_param: RTL and testbench
==================================

// Module: uart_fifo_param
// PURPOSE
//  Parametrised TX/RX FIFO for the UART 16550 core; one instance per direction.
//  Circular buffer with first-word-fall-through read, occupancy count and selectable trigger level.
//  Sticky overrun/underrun flags, per-entry error tags (parity/framing/break) and 16450 single-register mode.
//  Feeds the LSR/IIR logic: count, trigger, error-in-FIFO and the sticky flags.
// PARAMETERS
//  DATA_W   8         payload width per entry
//  ERR_W    3         error-tag width per entry (0 = no tags; err_* ports tied off)
//  DEPTH    16        entries; power of two, >= 2
//  TRIG_L0  1         trigger level for trig_sel=0
//  TRIG_L1  4         trigger level for trig_sel=1
//  TRIG_L2  8         trigger level for trig_sel=2
//  TRIG_L3  14        trigger level for trig_sel=3 (each level <= DEPTH)
// PORTS
//  clk        in   1            single clock, rising edge
//  rst_n      in   1            asynchronous, active-low reset
//  fifo_en    in   1            1 = FIFO mode (DEPTH entries), 0 = 16450 mode (1 entry)
//  flush      in   1            synchronous clear of contents
//  push       in   1            write request
//  din        in   DATA_W       write data
//  err_in     in   ERR_W        error tag stored with din
//  pop        in   1            read request; head is removed
//  dout       out  DATA_W       head data (FWFT); 0 when empty
//  err_out    out  ERR_W        head error tag; 0 when empty
//  count      out  CW           occupancy, CW = $clog2(DEPTH+1)
//  empty      out  1            count == 0
//  full       out  1            count == current capacity (DEPTH or 1)
//  trig_sel   in   2            trigger-level select
//  trig       out  1            count >= selected level
//  err_any    out  1            at least one stored entry has a nonzero tag
//  overrun    out  1            sticky: push rejected while full
//  underrun   out  1            sticky: pop rejected while empty
//  flag_clr   in   1            synchronous clear of overrun/underrun
// BEHAVIOUR
//  Reset: pointers, count, err counter, overrun and underrun = 0; empty=1, full=0, trig=0, dout=0, err_out=0.
//    Storage array is not reset.
//  Accept rules: push_ok = push & (~full | pop_ok); pop_ok = pop & ~empty. Evaluated on current state.
//  Full + push + pop: both accepted, count unchanged, no overrun.
//  Empty + push + pop: push accepted, pop rejected, underrun set.
//  Accepted push writes {err_in,din} at wr_ptr, wr_ptr+1. Accepted pop: rd_ptr+1.
//    Pointers wrap modulo DEPTH, are $clog2(DEPTH) bits wide, no extra wrap bit.
//  count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  Outputs: empty/full/trig derive from the registered count.
//    Data written at edge N is visible on dout after edge N (1-cycle write-to-read latency).
//  Overrun: push & ~push_ok sets overrun; rejected data is dropped and contents are untouched.
//  Underrun: pop & empty sets underrun.
//  Sticky-flag priority: a set event in the same cycle as flag_clr wins (flag stays 1).
//  err_any: internal counter of stored entries with |tag != 0. It increments on an accepted tagged push
//    and decrements on an accepted pop of a tagged head; both in one cycle leaves it unchanged.
//  16450 mode (fifo_en=0): capacity 1 and trig = ~empty regardless of trig_sel.
//  Any change of fifo_en (edge detected vs registered copy) performs an implicit flush that cycle.
//  Flush: ptrs, count and err counter go to 0 next edge. Flush beats push/pop in the same cycle:
//    requests are ignored and no overrun/underrun is raised. Sticky flags are not affected by flush.
//  trig_sel may change at any time; trig reflects the new level combinationally.
// STRUCTURE
//  uart_pkg: typedef enum logic [1:0] trig_sel_e {TRIG_1,TRIG_4,TRIG_8,TRIG_14}; CW helper function.
//  Sub-module uart_fifo_ram: DEPTH x (DATA_W+ERR_W) register array; 1 write port, async read port.
//  uart_fifo_param: pointers, count, err counter, flags and trigger compare.
// TESTING
//  Reset mid-burst (3 entries stored) -> count=0, empty=1, dout=0, flags 0 immediately on rst_n=0.
//  Push 0x01..0x10 (16), then 17th push 0xAA -> full=1, overrun=1; pop 16 -> 0x01..0x10 in order, 0xAA absent.
//  Full + simultaneous push 0x55/pop -> dout advances, count stays 16, overrun=0.
//    Drain: 0x55 is the last entry out.
//  trig_sel=2: pushes 1..7 -> trig=0; 8th push -> trig=1 after that edge.
//    trig_sel->3 -> trig=0; pop on empty -> underrun=1, cleared by flag_clr.
//  Push 0x41 tag 3'b010, then 0x42 tag 0 -> err_any=1. Pop -> err_out=3'b010 before the pop, err_any=0 after.
//  fifo_en=0: push 0x11, push 0x22 -> overrun=1, dout=0x11. Toggle fifo_en -> empty=1 next edge, overrun still 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART FIFO.
//   trig_sel_e : encodings of the 2-bit trigger-level select input
//   cw_f       : width needed to hold an occupancy of 0..depth
package uart_pkg;

  typedef enum logic [1:0] {
    TRIG_1  = 2'd0,
    TRIG_4  = 2'd1,
    TRIG_8  = 2'd2,
    TRIG_14 = 2'd3
  } trig_sel_e;

  function automatic int cw_f(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for uart_fifo_param: DEPTH words of W bits.
// Ports:
//   clk    in  rising-edge clock
//   we     in  write enable
//   waddr  in  write address (AW bits)
//   wdata  in  write data (W bits)
//   raddr  in  read address (AW bits)
//   rdata  out asynchronous read data (W bits)
module uart_fifo_ram #(
  parameter int W     = 11,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; the occupancy count alone decides which
  // words are meaningful, and a reset would only cost area and routing.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_param.sv
// TX/RX FIFO for the 16550 UART; one instance per direction.
// First-word-fall-through circular buffer with occupancy count, trigger
// level, sticky overrun/underrun flags and per-entry error tags.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   fifo_en             1 = DEPTH entries, 0 = 16450 single-entry mode
//   flush               synchronous clear of the contents
//   push, din, err_in   write request, data and error tag
//   pop                 read request (removes the head)
//   dout, err_out       head data/tag, 0 when empty
//   count, empty, full  occupancy status
//   trig_sel, trig      trigger-level select and count >= level
//   err_any             some stored entry carries a nonzero tag
//   overrun, underrun   sticky reject flags, cleared by flag_clr
module uart_fifo_param import uart_pkg::*; #(
  parameter  int DATA_W  = 8,
  parameter  int ERR_W   = 3,
  parameter  int DEPTH   = 16,
  parameter  int TRIG_L0 = 1,
  parameter  int TRIG_L1 = 4,
  parameter  int TRIG_L2 = 8,
  parameter  int TRIG_L3 = 14,
  localparam int CW      = cw_f(DEPTH),
  localparam int EW      = (ERR_W > 0) ? ERR_W : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_en,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic [EW-1:0]     err_in,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [EW-1:0]     err_out,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  input  logic [1:0]        trig_sel,
  output logic              trig,
  output logic              err_any,
  output logic              overrun,
  output logic              underrun,
  input  logic              flag_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = DATA_W + EW;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, err_cnt_q, err_cnt_d;
  logic          overrun_q, overrun_d, underrun_q, underrun_d;
  logic          fifo_en_q, fifo_en_d;

  logic          clr, push_ok, pop_ok, tag_in_nz, tag_head_nz;
  logic [CW-1:0] cap, lvl;
  logic [EW-1:0] tag_in, rd_tag;
  logic [W-1:0]  rd_word;

  // With ERR_W = 0 the tag lane is a single constant-zero bit.
  assign tag_in = (ERR_W > 0) ? err_in : '0;

  uart_fifo_ram #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata ({tag_in, din}),
    .raddr (rd_ptr_q),
    .rdata (rd_word)
  );

  assign rd_tag = (ERR_W > 0) ? rd_word[W-1:DATA_W] : '0;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    err_cnt_d  = err_cnt_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    fifo_en_d  = fifo_en;

    // A mode change reuses the flush path so stale entries never leak
    // across the capacity switch.
    clr   = flush | (fifo_en ^ fifo_en_q);
    cap   = fifo_en_q ? CW'(DEPTH) : CW'(1);
    empty = (count_q == '0);
    full  = (count_q == cap);

    pop_ok      = pop & ~empty & ~clr;
    push_ok     = push & (~full | pop_ok) & ~clr;
    tag_in_nz   = |tag_in;
    tag_head_nz = |rd_tag;

    if (clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      err_cnt_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      case ({push_ok & tag_in_nz, pop_ok & tag_head_nz})
        2'b10:   err_cnt_d = err_cnt_q + CW'(1);
        2'b01:   err_cnt_d = err_cnt_q - CW'(1);
        default: err_cnt_d = err_cnt_q;
      endcase
    end

    // Clear first, then set, so a same-cycle set event wins.
    if (flag_clr) begin
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end
    if (push & ~push_ok & ~clr) overrun_d  = 1'b1;
    if (pop & empty & ~clr)     underrun_d = 1'b1;

    case (trig_sel_e'(trig_sel))
      TRIG_1:  lvl = CW'(TRIG_L0);
      TRIG_4:  lvl = CW'(TRIG_L1);
      TRIG_8:  lvl = CW'(TRIG_L2);
      default: lvl = CW'(TRIG_L3);
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_cnt_q  <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      fifo_en_q  <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_cnt_q  <= err_cnt_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      fifo_en_q  <= fifo_en_d;
    end
  end

  assign count    = count_q;
  assign dout     = empty ? '0 : rd_word[DATA_W-1:0];
  assign err_out  = empty ? '0 : rd_tag;
  assign trig     = fifo_en_q ? (count_q >= lvl) : ~empty;
  assign err_any  = (err_cnt_q != '0);
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_uart_fifo_param.sv
// Directed bench for uart_fifo_param with default parameters.
module tb_uart_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n, fifo_en, flush, push, pop, flag_clr;
  logic [7:0] din, dout;
  logic [2:0] err_in, err_out;
  logic [4:0] count;
  logic [1:0] trig_sel;
  logic       empty, full, trig, err_any, overrun, underrun;

  int n_tests = 0;
  int n_fail  = 0;

  uart_fifo_param dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .fifo_en  (fifo_en),
    .flush    (flush),
    .push     (push),
    .din      (din),
    .err_in   (err_in),
    .pop      (pop),
    .dout     (dout),
    .err_out  (err_out),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .trig_sel (trig_sel),
    .trig     (trig),
    .err_any  (err_any),
    .overrun  (overrun),
    .underrun (underrun),
    .flag_clr (flag_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request; outputs are settled 1 time unit after the edge.
  task automatic cyc(input logic ps, input logic [7:0] d, input logic [2:0] e, input logic pp);
    push = ps; din = d; err_in = e; pop = pp;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; din = '0; err_in = '0;
  endtask

  initial begin
    rst_n = 1'b0; fifo_en = 1'b1; flush = 1'b0; push = 1'b0; pop = 1'b0;
    flag_clr = 1'b0; din = '0; err_in = '0; trig_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_trig", trig, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a burst.
    for (int i = 1; i <= 3; i++) cyc(1'b1, 8'(i), 3'd0, 1'b0);
    check("burst_count", count, 3);
    check("burst_dout", dout, 8'h01);
    rst_n = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_dout", dout, 0);
    check("midrst_ovr", overrun, 0);
    check("midrst_udr", underrun, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill to capacity, then one rejected push.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 3'd0, 1'b0);
    check("fill_count", count, 16);
    check("fill_full", full, 1);
    check("fill_ovr_pre", overrun, 0);
    cyc(1'b1, 8'hAA, 3'd0, 1'b0);
    check("ovr_set", overrun, 1);
    check("ovr_count", count, 16);
    for (int i = 1; i <= 16; i++) begin
      check("drain_order", dout, 8'(i));
      cyc(1'b0, 8'h00, 3'd0, 1'b1);
    end
    check("drain_empty", empty, 1);
    check("drain_dout", dout, 0);
    check("ovr_sticky", overrun, 1);
    flag_clr = 1'b1;
    cyc(1'b0, 8'h00, 3'd0, 1'b0);
    flag_clr = 1'b0;
    check("ovr_clr", overrun, 0);

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 3'd0, 1'b0);
    check("pp_dout_pre", dout, 8'h01);
    cyc(1'b1, 8'h55, 3'd0, 1'b1);
    check("pp_dout_post", dout, 8'h02);
    check("pp_count", count, 16);
    check("pp_ovr", overrun, 0);
    for (int i = 2; i <= 16; i++) begin
      check("pp_drain", dout, 8'(i));
      cyc(1'b0, 8'h00, 3'd0, 1'b1);
    end
    check("pp_last", dout, 8'h55);
    cyc(1'b0, 8'h00, 3'd0, 1'b1);
    check("pp_empty", empty, 1);

    // Trigger levels.
    trig_sel = 2'd2;
    for (int i = 1; i <= 7; i++) cyc(1'b1, 8'(i), 3'd0, 1'b0);
    check("trig8_at7", trig, 0);
    cyc(1'b1, 8'h08, 3'd0, 1'b0);
    check("trig8_at8", trig, 1);
    trig_sel = 2'd3;
    #1;
    check("trig14_at8", trig, 0);
    flush = 1'b1;
    cyc(1'b0, 8'h00, 3'd0, 1'b0);
    flush = 1'b0;
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);

    // Underrun, and set-beats-clear.
    cyc(1'b0, 8'h00, 3'd0, 1'b1);
    check("udr_set", underrun, 1);
    flag_clr = 1'b1;
    cyc(1'b0, 8'h00, 3'd0, 1'b1);
    check("udr_set_wins", underrun, 1);
    cyc(1'b0, 8'h00, 3'd0, 1'b0);
    flag_clr = 1'b0;
    check("udr_clr", underrun, 0);

    // Error tags.
    cyc(1'b1, 8'h41, 3'b010, 1'b0);
    cyc(1'b1, 8'h42, 3'b000, 1'b0);
    check("tag_err_any", err_any, 1);
    check("tag_err_out", err_out, 3'b010);
    check("tag_dout", dout, 8'h41);
    cyc(1'b0, 8'h00, 3'd0, 1'b1);
    check("tag_err_any_post", err_any, 0);
    check("tag_err_out_post", err_out, 0);
    check("tag_dout_post", dout, 8'h42);
    cyc(1'b0, 8'h00, 3'd0, 1'b1);

    // Empty with push and pop: push kept, underrun raised.
    cyc(1'b1, 8'h77, 3'd0, 1'b1);
    check("ep_count", count, 1);
    check("ep_dout", dout, 8'h77);
    check("ep_udr", underrun, 1);

    // Flush beats requests and raises no flags.
    flag_clr = 1'b1;
    cyc(1'b0, 8'h00, 3'd0, 1'b0);
    flag_clr = 1'b0;
    flush = 1'b1;
    cyc(1'b1, 8'h99, 3'd0, 1'b1);
    flush = 1'b0;
    check("fl_count", count, 0);
    check("fl_udr", underrun, 0);
    check("fl_ovr", overrun, 0);

    // 16450 single-register mode.
    fifo_en = 1'b0;
    cyc(1'b0, 8'h00, 3'd0, 1'b0);
    cyc(1'b1, 8'h11, 3'd0, 1'b0);
    check("m50_full", full, 1);
    check("m50_trig", trig, 1);
    cyc(1'b1, 8'h22, 3'd0, 1'b0);
    check("m50_ovr", overrun, 1);
    check("m50_dout", dout, 8'h11);
    check("m50_count", count, 1);
    fifo_en = 1'b1;
    cyc(1'b1, 8'h33, 3'd0, 1'b0);
    check("mchg_empty", empty, 1);
    check("mchg_ovr", overrun, 1);
    cyc(1'b1, 8'h34, 3'd0, 1'b0);
    check("mchg_fifo_count", count, 1);
    check("mchg_full", full, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
